alu_ctrl_muldiv: RTL and testbench
==================================

# alu_ctrl_muldiv

Parametrised execute-stage control and arithmetic unit for the pipelined MIPS core. It extends the ALU control decode with NOR, XOR, SLL and SRL. It adds an iterative unsigned multiply/divide engine with HI/LO registers and a busy/stall handshake to the hazard unit. Single-cycle operations complete with registered one-cycle latency. MULTU and DIVU run for WIDTH cycles.

## Interface
- WIDTH, 32: datapath width; must be ≥ 4.
- SHW, $clog2(WIDTH): shift-amount width.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  operation presented this cycle.
- Alu_op  in  2  main-decoder ALU op class.
- funct  in  6  R-type function field.
- src_a  in  WIDTH  operand A (rs).
- src_b  in  WIDTH  operand B (rt, or sign-extended immediate).
- shamt  in  SHW  shift amount.
- Alu_ctrl  out  4  combinational decoded operation code.
- result  out  WIDTH  registered single-cycle result.
- result_valid  out  1  result holds a new value this cycle.
- illegal_op  out  1  registered; accompanies result_valid for an undecodable funct.
- busy  out  1  multiply/divide in progress; the pipeline must stall.
- md_done  out  1  one-cycle pulse: HI/LO were just updated.
- div_by_zero  out  1  registered; set with md_done for DIVU with src_b == 0.
- hi, lo  out  WIDTH each  HI/LO architectural registers.

## Operation
- Alu_ctrl decode by Alu_op:
  - 00 → 0010 (add).
  - 01 → 0110 (sub).
  - 11 → 0010 (add).
  - 10 → by funct: 100000 add 0010; 100010 sub 0110; 100100 and 0000; 100101 or 0001; 101010 slt 0111; 100111 nor 1100; 100110 xor 0011; 000000 sll 1000; 000010 srl 1001; 011001 multu 1010; 011011 divu 1011; 010000 mfhi 1101; 010010 mflo 1110.
  - Any other funct → 1111. No X outputs.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH.
  - slt is a signed compare, zero-extended to WIDTH.
  - sll/srl shift src_b by shamt; srl is logical.
  - mfhi/mflo return hi/lo.
- Code 1111: result = 0, illegal_op = 1, result_valid = 1.
- FSM states: IDLE, MUL, DIV.
  - IDLE → MUL on valid_in with code 1010.
  - IDLE → DIV on valid_in with code 1011.
  - On entry, operands are latched and the counter is loaded with WIDTH.
  - MUL/DIV → IDLE when the counter reaches 0. On that transition hi/lo are written.
- MUL: shift-add, unsigned. {hi, lo} = src_a × src_b (2·WIDTH-bit product).
- DIV: restoring, unsigned, one quotient bit per cycle. lo = quotient, hi = remainder.
  - For src_b == 0: lo = all ones, hi = src_a, div_by_zero = 1.
- busy = (state != IDLE). valid_in is ignored while busy: no result_valid, no state change.
- MULTU/DIVU never assert result_valid.
- Reset, including mid-operation:
  - state → IDLE, counter → 0.
  - hi, lo, result → 0.
  - result_valid, illegal_op, md_done, div_by_zero → 0.
  - busy is 0 in the cycle after rst is sampled.

## Timing
- Single-cycle ops: valid_in sampled at edge t; result and result_valid visible after edge t, for one cycle only.
- Back-to-back single-cycle ops sustain one result per cycle.
- Multi-cycle ops: accepted at edge t.
  - busy = 1 for exactly WIDTH cycles, after edges t … t+WIDTH−1.
  - At edge t+WIDTH: hi/lo are updated, md_done = 1 for one cycle, busy = 0.
- An op presented in the md_done cycle is accepted normally. mfhi/mflo in that cycle read the new hi/lo.
- Alu_ctrl is purely combinational from Alu_op/funct, independent of valid_in and busy.
- div_by_zero holds until the next md_done or reset.

## Test plan
- Reset, then valid_in, Alu_op=10, funct=100000, src_a=5, src_b=7 → next cycle result=12, result_valid=1, Alu_ctrl=0010. Repeat with funct=101010, src_a=0xFFFFFFFF, src_b=1 → result=1.
- MULTU with src_a=0xFFFFFFFF, src_b=2 (WIDTH=32) → busy high for 32 cycles, then md_done with hi=1, lo=0xFFFFFFFE. Follow-up mflo → result=0xFFFFFFFE.
- DIVU 100/7 → lo=14, hi=2, div_by_zero=0. DIVU 0x1234/0 → lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1.
- Present add ops every cycle during MULTU busy → no result_valid, hi/lo unchanged until md_done. Op issued in the md_done cycle → accepted, result next cycle.
- Assert rst at busy cycle 10 of DIVU → the following cycle busy=0, hi=lo=0, no md_done ever for that op.
- funct=111111 with Alu_op=10 → Alu_ctrl=1111, next cycle result=0, illegal_op=1. Alu_op=01 → Alu_ctrl=0110 for any funct.

Source files
------------

// File: rtl/alu_ctrl_muldiv_if.sv
// Execute-stage bus between the pipeline/hazard unit and the ALU control + mul/div unit.
// master drives operation requests; slave returns results and the busy/stall status.
interface alu_ctrl_muldiv_if #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
);
   logic             valid_in;
   logic [1:0]       Alu_op;
   logic [5:0]       funct;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic [SHW-1:0]   shamt;

   logic [3:0]       Alu_ctrl;
   logic [WIDTH-1:0] result;
   logic             result_valid;
   logic             illegal_op;
   logic             busy;
   logic             md_done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output valid_in, Alu_op, funct, src_a, src_b, shamt,
      input  Alu_ctrl, result, result_valid, illegal_op, busy, md_done,
             div_by_zero, hi, lo
   );

   modport slave (
      input  valid_in, Alu_op, funct, src_a, src_b, shamt,
      output Alu_ctrl, result, result_valid, illegal_op, busy, md_done,
             div_by_zero, hi, lo
   );
endinterface

// File: rtl/alu_ctrl_muldiv.sv
// MIPS execute-stage ALU control decode, registered single-cycle ALU, and an
// iterative unsigned multiply/divide engine with HI/LO registers.
module alu_ctrl_muldiv #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic               clk,
   input logic               rst,
   alu_ctrl_muldiv_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] C_AND  = 4'b0000;
   localparam logic [3:0] C_OR   = 4'b0001;
   localparam logic [3:0] C_ADD  = 4'b0010;
   localparam logic [3:0] C_XOR  = 4'b0011;
   localparam logic [3:0] C_SUB  = 4'b0110;
   localparam logic [3:0] C_SLT  = 4'b0111;
   localparam logic [3:0] C_SLL  = 4'b1000;
   localparam logic [3:0] C_SRL  = 4'b1001;
   localparam logic [3:0] C_MUL  = 4'b1010;
   localparam logic [3:0] C_DIV  = 4'b1011;
   localparam logic [3:0] C_NOR  = 4'b1100;
   localparam logic [3:0] C_MFHI = 4'b1101;
   localparam logic [3:0] C_MFLO = 4'b1110;
   localparam logic [3:0] C_ILL  = 4'b1111;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   p_q, p_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0]     res_q, res_d;
   logic                 rv_q, rv_d, ill_q, ill_d, done_q, done_d, dbz_q, dbz_d;

   logic [3:0]           ctrl;
   logic [WIDTH-1:0]     a, b, alu_res;
   logic [SHW-1:0]       sh;
   logic [WIDTH:0]       mul_sum, rem_sh, rem_diff;
   logic [2*WIDTH-1:0]   mul_nxt, div_nxt;

   assign a  = bus.src_a;
   assign b  = bus.src_b;
   assign sh = bus.shamt;

   always_comb begin
      ctrl = C_ADD;
      unique case (bus.Alu_op)
         2'b01: ctrl = C_SUB;
         2'b10: begin
            case (bus.funct)
               6'b100000: ctrl = C_ADD;
               6'b100010: ctrl = C_SUB;
               6'b100100: ctrl = C_AND;
               6'b100101: ctrl = C_OR;
               6'b101010: ctrl = C_SLT;
               6'b100111: ctrl = C_NOR;
               6'b100110: ctrl = C_XOR;
               6'b000000: ctrl = C_SLL;
               6'b000010: ctrl = C_SRL;
               6'b011001: ctrl = C_MUL;
               6'b011011: ctrl = C_DIV;
               6'b010000: ctrl = C_MFHI;
               6'b010010: ctrl = C_MFLO;
               default:   ctrl = C_ILL;
            endcase
         end
         default: ctrl = C_ADD;
      endcase
   end

   // mfhi/mflo read the registers directly, so the md_done cycle already sees new values
   always_comb begin
      alu_res = '0;
      case (ctrl)
         C_ADD:   alu_res = a + b;
         C_SUB:   alu_res = a - b;
         C_AND:   alu_res = a & b;
         C_OR:    alu_res = a | b;
         C_XOR:   alu_res = a ^ b;
         C_NOR:   alu_res = ~(a | b);
         C_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         C_SLL:   alu_res = b << sh;
         C_SRL:   alu_res = b >> sh;
         C_MFHI:  alu_res = hi_q;
         C_MFLO:  alu_res = lo_q;
         default: alu_res = '0;
      endcase
   end

   // p_q is shared: MUL keeps {partial product, multiplier}, DIV keeps {remainder, dividend/quotient}
   always_comb begin
      mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? m_q : {WIDTH{1'b0}})};
      mul_nxt  = {mul_sum, p_q[WIDTH-1:1]};
      rem_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, m_q};
      if (!rem_diff[WIDTH])
         div_nxt = {rem_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
      else
         div_nxt = {rem_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      m_d     = m_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      res_d   = res_q;
      rv_d    = 1'b0;
      ill_d   = 1'b0;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.valid_in) begin
               if (ctrl == C_MUL) begin
                  state_d = S_MUL;
                  cnt_d   = CW'(WIDTH);
                  m_d     = a;
                  p_d     = {{WIDTH{1'b0}}, b};
               end else if (ctrl == C_DIV) begin
                  state_d = S_DIV;
                  cnt_d   = CW'(WIDTH);
                  m_d     = b;
                  p_d     = {{WIDTH{1'b0}}, a};
               end else begin
                  res_d = alu_res;
                  rv_d  = 1'b1;
                  ill_d = (ctrl == C_ILL);
               end
            end
         end
         S_MUL, S_DIV: begin
            cnt_d = cnt_q - CW'(1);
            p_d   = (state_q == S_MUL) ? mul_nxt : div_nxt;
            if (cnt_d == '0) begin
               state_d = S_IDLE;
               hi_d    = p_d[2*WIDTH-1:WIDTH];
               lo_d    = p_d[WIDTH-1:0];
               done_d  = 1'b1;
               dbz_d   = (state_q == S_DIV) && (m_q == '0);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         m_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         res_q   <= '0;
         rv_q    <= 1'b0;
         ill_q   <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         m_q     <= m_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         res_q   <= res_d;
         rv_q    <= rv_d;
         ill_q   <= ill_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign bus.Alu_ctrl     = ctrl;
   assign bus.result       = res_q;
   assign bus.result_valid = rv_q;
   assign bus.illegal_op   = ill_q;
   assign bus.busy         = (state_q != S_IDLE);
   assign bus.md_done      = done_q;
   assign bus.div_by_zero  = dbz_q;
   assign bus.hi           = hi_q;
   assign bus.lo           = lo_q;
endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Randomised + directed check of alu_ctrl_muldiv against a plain-arithmetic model.
module tb_alu_ctrl_muldiv;
   localparam int W  = 32;
   localparam int SW = $clog2(W);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_ctrl_muldiv_if #(.WIDTH(W), .SHW(SW)) bus ();
   alu_ctrl_muldiv #(.WIDTH(W), .SHW(SW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   int total = 0;
   int bad   = 0;
   logic [W-1:0] mhi, mlo;
   logic         mdbz;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [SW-1:0] sh);
      bus.valid_in = v;
      bus.Alu_op   = op;
      bus.funct    = f;
      bus.src_a    = a;
      bus.src_b    = b;
      bus.shamt    = sh;
   endtask

   function automatic logic [3:0] exp_ctrl(input logic [1:0] op, input logic [5:0] f);
      if (op == 2'b01) return 4'b0110;
      if (op != 2'b10) return 4'b0010;
      case (f)
         6'b100000: return 4'b0010;
         6'b100010: return 4'b0110;
         6'b100100: return 4'b0000;
         6'b100101: return 4'b0001;
         6'b101010: return 4'b0111;
         6'b100111: return 4'b1100;
         6'b100110: return 4'b0011;
         6'b000000: return 4'b1000;
         6'b000010: return 4'b1001;
         6'b011001: return 4'b1010;
         6'b011011: return 4'b1011;
         6'b010000: return 4'b1101;
         6'b010010: return 4'b1110;
         default:   return 4'b1111;
      endcase
   endfunction

   // result by instruction meaning, computed with plain integer arithmetic
   function automatic logic [W-1:0] exp_res(input logic [1:0] op, input logic [5:0] f,
                                            input logic [W-1:0] a, input logic [W-1:0] b,
                                            input int sh);
      longint unsigned ua = a, ub = b;
      if (op == 2'b01) return W'(ua - ub);
      if (op != 2'b10) return W'(ua + ub);
      case (f)
         6'b100000: return W'(ua + ub);
         6'b100010: return W'(ua - ub);
         6'b100100: return a & b;
         6'b100101: return a | b;
         6'b101010: return (int'(a) < int'(b)) ? 1 : 0;
         6'b100111: return ~(a | b);
         6'b100110: return a ^ b;
         6'b000000: return W'(ub * (64'd1 << sh));
         6'b000010: return W'(ub / (64'd1 << sh));
         6'b010000: return mhi;
         6'b010010: return mlo;
         default:   return '0;
      endcase
   endfunction

   task automatic alu_op(input string tag, input logic [1:0] op, input logic [5:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [SW-1:0] sh);
      logic [W-1:0] e;
      logic         ill;
      drive(1'b1, op, f, a, b, sh);
      #1;
      chk({tag, " ctrl"}, bus.Alu_ctrl, exp_ctrl(op, f));
      e   = exp_res(op, f, a, b, int'(sh));
      ill = (exp_ctrl(op, f) == 4'b1111);
      step();
      chk({tag, " rv"}, bus.result_valid, 1'b1);
      chk({tag, " res"}, bus.result, e);
      chk({tag, " ill"}, bus.illegal_op, ill);
   endtask

   task automatic md(input string tag, input bit isdiv, input logic [W-1:0] a,
                     input logic [W-1:0] b, input bit stuff);
      int n = 0;
      longint unsigned prod;
      drive(1'b1, 2'b10, isdiv ? 6'b011011 : 6'b011001, a, b, '0);
      step();
      if (stuff) drive(1'b1, 2'b00, 6'b100000, a ^ 32'h1, b, '0);
      else bus.valid_in = 1'b0;
      while (bus.busy === 1'b1 && n < 100) begin
         n++;
         chk({tag, " busy rv"}, bus.result_valid, 1'b0);
         chk({tag, " early done"}, bus.md_done, 1'b0);
         chk({tag, " hilo held"}, {bus.hi, bus.lo}, {mhi, mlo});
         step();
      end
      if (!isdiv) begin
         prod = 64'(a) * 64'(b);
         {mhi, mlo} = prod;
         mdbz = 1'b0;
      end else if (b == 0) begin
         mhi = a; mlo = '1; mdbz = 1'b1;
      end else begin
         mhi = a % b; mlo = a / b; mdbz = 1'b0;
      end
      chk({tag, " busy cycles"}, 64'(n), 64'(W));
      chk({tag, " md_done"}, bus.md_done, 1'b1);
      chk({tag, " hi"}, bus.hi, mhi);
      chk({tag, " lo"}, bus.lo, mlo);
      chk({tag, " dbz"}, bus.div_by_zero, mdbz);
      alu_op({tag, " mflo"}, 2'b10, 6'b010010, $urandom, $urandom, '0);
      chk({tag, " done pulse"}, bus.md_done, 1'b0);
      alu_op({tag, " mfhi"}, 2'b10, 6'b010000, $urandom, $urandom, '0);
      chk({tag, " dbz hold"}, bus.div_by_zero, mdbz);
      bus.valid_in = 1'b0;
   endtask

   logic [5:0] legal [11] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                              6'b100111, 6'b100110, 6'b000000, 6'b000010, 6'b010000, 6'b010010};

   initial begin
      int dn;
      drive(1'b0, 2'b00, '0, '0, '0, '0);
      mhi = '0; mlo = '0; mdbz = 1'b0;
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      chk("rst result", bus.result, '0);
      chk("rst rv", bus.result_valid, 1'b0);
      chk("rst busy", bus.busy, 1'b0);
      chk("rst hilo", {bus.hi, bus.lo}, '0);
      chk("rst done", bus.md_done, 1'b0);
      chk("rst dbz", bus.div_by_zero, 1'b0);
      chk("rst ill", bus.illegal_op, 1'b0);

      alu_op("add 5+7", 2'b10, 6'b100000, 32'd5, 32'd7, '0);
      alu_op("slt -1<1", 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, '0);
      bus.valid_in = 1'b0;
      step();
      chk("rv one cycle", bus.result_valid, 1'b0);

      alu_op("illegal", 2'b10, 6'b111111, 32'h55, 32'h66, '0);
      for (int i = 0; i < 4; i++)
         alu_op("op01 sub", 2'b01, 6'($urandom), $urandom, $urandom, '0);

      md("multu", 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1);
      md("divu 100/7", 1'b1, 32'd100, 32'd7, 1'b0);
      md("divu /0", 1'b1, 32'h1234, 32'd0, 1'b1);
      alu_op("dbz after", 2'b10, 6'b100100, $urandom, $urandom, '0);
      chk("dbz sticky", bus.div_by_zero, 1'b1);
      bus.valid_in = 1'b0;

      // back-to-back random single-cycle ops
      for (int i = 0; i < 60; i++) begin
         logic [1:0] op = 2'($urandom_range(0, 3));
         logic [5:0] f  = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legal[$urandom_range(0, 10)];
         if (op == 2'b10 && (f == 6'b011001 || f == 6'b011011)) f = 6'b100000;
         alu_op("rand alu", op, f, $urandom, $urandom, SW'($urandom));
      end
      bus.valid_in = 1'b0;

      for (int i = 0; i < 6; i++) begin
         logic [W-1:0] b = (i == 4) ? '0 : ((i % 3 == 0) ? W'($urandom_range(1, 50)) : W'($urandom));
         md("rand md", i[0], $urandom, b, i[1]);
      end

      // reset in the middle of a divide
      drive(1'b1, 2'b10, 6'b011011, 32'hDEAD_BEEF, 32'd3, '0);
      step();
      bus.valid_in = 1'b0;
      repeat (9) step();
      chk("mid busy", bus.busy, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      mhi = '0; mlo = '0; mdbz = 1'b0;
      chk("mid rst busy", bus.busy, 1'b0);
      chk("mid rst hi", bus.hi, '0);
      chk("mid rst lo", bus.lo, '0);
      chk("mid rst result", bus.result, '0);
      chk("mid rst dbz", bus.div_by_zero, 1'b0);
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.md_done === 1'b1 || bus.busy === 1'b1) dn++;
         step();
      end
      chk("mid rst no done", 64'(dn), 64'd0);
      md("post rst multu", 1'b0, 32'd12345, 32'd678, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
